// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I multi-cycle control path.
// Opcodes, mux selects, opcode classes and sequencer states.
package rv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_ALU    = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_BRANCH = 2'd2;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_SYSTEM  = 2'd2;

    localparam logic [3:0] CLS_R       = 4'd0;
    localparam logic [3:0] CLS_OPIMM   = 4'd1;
    localparam logic [3:0] CLS_LOAD    = 4'd2;
    localparam logic [3:0] CLS_STORE   = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_JAL     = 4'd5;
    localparam logic [3:0] CLS_JALR    = 4'd6;
    localparam logic [3:0] CLS_LUI     = 4'd7;
    localparam logic [3:0] CLS_AUIPC   = 4'd8;
    localparam logic [3:0] CLS_SYSTEM  = 4'd9;
    localparam logic [3:0] CLS_ILLEGAL = 4'd10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

endpackage

// File: rtl/rv_opcode_class.sv
// Opcode classifier: instr[6:0] to class, immediate format and trap flags.
// Purely combinational; shared with the single-cycle decoder.
module rv_opcode_class
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] cls,
    output logic [2:0] imm_sel,
    output logic       illegal,
    output logic       system
);

    // Map each opcode to its class; unknown opcodes are illegal.
    always_comb begin
        cls     = CLS_ILLEGAL;
        imm_sel = IMM_NONE;
        illegal = 1'b1;
        system  = 1'b0;
        unique case (1'b1)
            (opcode == OP_REG): begin
                cls     = CLS_R;
                illegal = 1'b0;
            end
            (opcode == OP_IMM): begin
                cls     = CLS_OPIMM;
                imm_sel = IMM_I;
                illegal = 1'b0;
            end
            (opcode == OP_LOAD): begin
                cls     = CLS_LOAD;
                imm_sel = IMM_I;
                illegal = 1'b0;
            end
            (opcode == OP_JALR): begin
                cls     = CLS_JALR;
                imm_sel = IMM_I;
                illegal = 1'b0;
            end
            (opcode == OP_STORE): begin
                cls     = CLS_STORE;
                imm_sel = IMM_S;
                illegal = 1'b0;
            end
            (opcode == OP_BRANCH): begin
                cls     = CLS_BRANCH;
                imm_sel = IMM_B;
                illegal = 1'b0;
            end
            (opcode == OP_LUI): begin
                cls     = CLS_LUI;
                imm_sel = IMM_U;
                illegal = 1'b0;
            end
            (opcode == OP_AUIPC): begin
                cls     = CLS_AUIPC;
                imm_sel = IMM_U;
                illegal = 1'b0;
            end
            (opcode == OP_JAL): begin
                cls     = CLS_JAL;
                imm_sel = IMM_J;
                illegal = 1'b0;
            end
            (opcode == OP_SYSTEM): begin
                cls     = CLS_SYSTEM;
                illegal = 1'b0;
                system  = 1'b1;
            end
            default: begin
                cls     = CLS_ILLEGAL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Outputs decode from state and opcode; strobes are forced low in rst.
module rv_multicycle_ctrl
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  trap_cause
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] cause_q;
    logic [1:0] cause_d;

    logic [3:0] cls;
    logic [2:0] dec_imm;
    logic       dec_illegal;
    logic       dec_system;

    logic       mem_req_c;
    logic       mem_we_c;
    logic       mem_addr_sel_c;
    logic       pc_we_c;
    logic       ir_we_c;
    logic       reg_we_c;
    logic       retire_c;

    rv_opcode_class u_class (
        .opcode  (instr[6:0]),
        .cls     (cls),
        .imm_sel (dec_imm),
        .illegal (dec_illegal),
        .system  (dec_system)
    );

    // State and latched trap cause; the cause is only written on trap entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and datapath controls for the current state and class.
    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        pc_we_c        = 1'b0;
        pc_src         = PC_PLUS4;
        ir_we_c        = 1'b0;
        imm_sel        = IMM_NONE;
        alu_src_a      = SRC_A_RS1;
        alu_src_b      = SRC_B_RS2;
        alu_op         = ALU_ADD;
        reg_we_c       = 1'b0;
        wb_sel         = WB_ALU;
        retire_c       = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                imm_sel = dec_imm;
                if (dec_system) begin
                    state_d = S_TRAP;
                    cause_d = TRAP_SYSTEM;
                end else if (dec_illegal) begin
                    state_d = S_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                imm_sel = dec_imm;
                state_d = S_WB;
                unique case (cls)
                    CLS_R: begin
                        alu_op = ALU_FUNCT;
                    end
                    CLS_OPIMM: begin
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_FUNCT;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b = SRC_B_IMM;
                        state_d   = S_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op   = ALU_BRANCH;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                        if (branch_taken) begin
                            pc_we_c = 1'b1;
                            pc_src  = PC_BRANCH;
                        end
                    end
                    CLS_JAL, CLS_AUIPC: begin
                        alu_src_a = SRC_A_PC;
                        alu_src_b = SRC_B_IMM;
                    end
                    CLS_JALR: begin
                        alu_src_b = SRC_B_IMM;
                    end
                    CLS_LUI: begin
                        alu_src_a = SRC_A_ZERO;
                        alu_src_b = SRC_B_IMM;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                imm_sel        = dec_imm;
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_STORE) begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end
            end

            S_WB: begin
                imm_sel  = dec_imm;
                reg_we_c = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
                if (cls == CLS_LOAD) begin
                    wb_sel = WB_LOAD;
                end else if (cls == CLS_JAL || cls == CLS_JALR) begin
                    wb_sel  = WB_LINK;
                    pc_we_c = 1'b1;
                    pc_src  = PC_ALU;
                end
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes and status are silenced for the whole reset cycle.
    always_comb begin
        mem_req      = mem_req_c & ~rst;
        mem_we       = mem_we_c & ~rst;
        mem_addr_sel = mem_addr_sel_c & ~rst;
        pc_we        = pc_we_c & ~rst;
        ir_we        = ir_we_c & ~rst;
        reg_we       = reg_we_c & ~rst;
        retire       = retire_c & ~rst;
        halted       = (state_q == S_TRAP) & ~rst;
        trap_cause   = rst ? TRAP_NONE : cause_q;
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl.
// Stimulus queues per-cycle expectations; a monitor pops and compares.
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic        halted;
    logic [1:0]  trap_cause;

    int total = 0;
    int bad = 0;

    typedef struct {
        string      name;
        logic       dc_imm;
        logic       dc_alu;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic [2:0] imm_sel;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       retire;
        logic       halted;
        logic [1:0] trap_cause;
    } exp_t;

    exp_t exp_q[$];

    rv_multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .ir_we        (ir_we),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .retire       (retire),
        .halted       (halted),
        .trap_cause   (trap_cause)
    );

    always #5 clk = ~clk;

    function automatic exp_t base(string n, logic dci, logic dca);
        exp_t e;
        e.name = n;
        e.dc_imm = dci;
        e.dc_alu = dca;
        e.mem_req = 0;
        e.mem_we = 0;
        e.mem_addr_sel = 0;
        e.pc_we = 0;
        e.pc_src = 0;
        e.ir_we = 0;
        e.imm_sel = 3'd7;
        e.alu_src_a = 0;
        e.alu_src_b = 0;
        e.alu_op = 0;
        e.reg_we = 0;
        e.wb_sel = 0;
        e.retire = 0;
        e.halted = 0;
        e.trap_cause = 0;
        return e;
    endfunction

    function automatic exp_t e_fetch(string n, logic rdy);
        exp_t e = base(n, 1, 1);
        e.mem_req = 1;
        e.ir_we = rdy;
        e.pc_we = rdy;
        e.pc_src = 2'd0;
        return e;
    endfunction

    function automatic exp_t e_dec(string n, logic [2:0] imm, logic dci);
        exp_t e = base(n, dci, 1);
        e.imm_sel = imm;
        return e;
    endfunction

    function automatic exp_t e_exec(string n, logic [2:0] imm,
                                    logic [1:0] a, logic b,
                                    logic [1:0] op, logic pcwe,
                                    logic [1:0] src, logic ret);
        exp_t e = base(n, 0, 0);
        e.imm_sel = imm;
        e.alu_src_a = a;
        e.alu_src_b = b;
        e.alu_op = op;
        e.pc_we = pcwe;
        e.pc_src = src;
        e.retire = ret;
        return e;
    endfunction

    function automatic exp_t e_mem(string n, logic [2:0] imm,
                                   logic we, logic ret);
        exp_t e = base(n, 0, 1);
        e.imm_sel = imm;
        e.mem_req = 1;
        e.mem_addr_sel = 1;
        e.mem_we = we;
        e.retire = ret;
        return e;
    endfunction

    function automatic exp_t e_wb(string n, logic [2:0] imm,
                                  logic [1:0] ws, logic pcwe);
        exp_t e = base(n, 0, 1);
        e.imm_sel = imm;
        e.reg_we = 1;
        e.wb_sel = ws;
        e.pc_we = pcwe;
        e.pc_src = 2'd1;
        e.retire = 1;
        return e;
    endfunction

    function automatic exp_t e_trap(string n, logic [1:0] cause);
        exp_t e = base(n, 1, 1);
        e.halted = 1;
        e.trap_cause = cause;
        return e;
    endfunction

    task automatic cyc(exp_t e, logic r, logic rdy, logic bt);
        rst = r;
        mem_ready = rdy;
        branch_taken = bt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs against the next queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic miss;
            e = exp_q.pop_front();
            miss = (mem_req !== e.mem_req) ||
                   (e.mem_req && (mem_addr_sel !== e.mem_addr_sel)) ||
                   (e.mem_req && (mem_we !== e.mem_we)) ||
                   (pc_we !== e.pc_we) ||
                   (e.pc_we && (pc_src !== e.pc_src)) ||
                   (ir_we !== e.ir_we) ||
                   (!e.dc_imm && (imm_sel !== e.imm_sel)) ||
                   (!e.dc_alu && (alu_src_a !== e.alu_src_a)) ||
                   (!e.dc_alu && (alu_src_b !== e.alu_src_b)) ||
                   (!e.dc_alu && (alu_op !== e.alu_op)) ||
                   (reg_we !== e.reg_we) ||
                   (e.reg_we && (wb_sel !== e.wb_sel)) ||
                   (retire !== e.retire) ||
                   (halted !== e.halted) ||
                   (trap_cause !== e.trap_cause);
            total++;
            if (miss) begin
                bad++;
                $display({"FAIL %s: got req=%b we=%b as=%b pcwe=%b ps=%0d ",
                          "irwe=%b imm=%0d a=%0d b=%b op=%0d rwe=%b ws=%0d ",
                          "ret=%b h=%b tc=%0d | want req=%b we=%b as=%b ",
                          "pcwe=%b ps=%0d irwe=%b imm=%0d a=%0d b=%b op=%0d ",
                          "rwe=%b ws=%0d ret=%b h=%b tc=%0d"},
                         e.name, mem_req, mem_we, mem_addr_sel, pc_we,
                         pc_src, ir_we, imm_sel, alu_src_a, alu_src_b,
                         alu_op, reg_we, wb_sel, retire, halted,
                         trap_cause, e.mem_req, e.mem_we, e.mem_addr_sel,
                         e.pc_we, e.pc_src, e.ir_we, e.imm_sel,
                         e.alu_src_a, e.alu_src_b, e.alu_op, e.reg_we,
                         e.wb_sel, e.retire, e.halted, e.trap_cause);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        cyc(base("rst0", 1, 1), 1, 0, 0);
        cyc(base("rst1", 1, 1), 1, 1, 0);

        instr = 32'h00208033;
        cyc(e_fetch("add_f", 1), 0, 1, 0);
        cyc(e_dec("add_d", 3'd7, 0), 0, 1, 0);
        cyc(e_exec("add_e", 3'd7, 0, 0, 1, 0, 0, 0), 0, 1, 0);
        cyc(e_wb("add_wb", 3'd7, 0, 0), 0, 1, 0);

        instr = 32'h0000A083;
        cyc(e_fetch("lw_fw0", 0), 0, 0, 0);
        cyc(e_fetch("lw_fw1", 0), 0, 0, 0);
        cyc(e_fetch("lw_f", 1), 0, 1, 0);
        cyc(e_dec("lw_d", 3'd0, 0), 0, 1, 0);
        cyc(e_exec("lw_e", 3'd0, 0, 1, 0, 0, 0, 0), 0, 0, 0);
        cyc(e_mem("lw_mw", 3'd0, 0, 0), 0, 0, 0);
        cyc(e_mem("lw_m", 3'd0, 0, 0), 0, 1, 0);
        cyc(e_wb("lw_wb", 3'd0, 1, 0), 0, 1, 0);

        instr = 32'h0020A023;
        cyc(e_fetch("sw_f", 1), 0, 1, 0);
        cyc(e_dec("sw_d", 3'd1, 0), 0, 1, 0);
        cyc(e_exec("sw_e", 3'd1, 0, 1, 0, 0, 0, 0), 0, 1, 0);
        cyc(e_mem("sw_m", 3'd1, 1, 1), 0, 1, 0);

        instr = 32'h00000463;
        cyc(e_fetch("beqt_f", 1), 0, 1, 0);
        cyc(e_dec("beqt_d", 3'd2, 0), 0, 1, 0);
        cyc(e_exec("beqt_e", 3'd2, 0, 0, 2, 1, 2, 1), 0, 1, 1);
        cyc(e_fetch("beqn_f", 1), 0, 1, 0);
        cyc(e_dec("beqn_d", 3'd2, 0), 0, 1, 0);
        cyc(e_exec("beqn_e", 3'd2, 0, 0, 2, 0, 0, 1), 0, 1, 0);

        instr = 32'h008000EF;
        cyc(e_fetch("jal_f", 1), 0, 1, 0);
        cyc(e_dec("jal_d", 3'd4, 0), 0, 1, 0);
        cyc(e_exec("jal_e", 3'd4, 1, 1, 0, 0, 0, 0), 0, 1, 0);
        cyc(e_wb("jal_wb", 3'd4, 2, 1), 0, 1, 0);

        instr = 32'h000080E7;
        cyc(e_fetch("jalr_f", 1), 0, 1, 0);
        cyc(e_dec("jalr_d", 3'd0, 0), 0, 1, 0);
        cyc(e_exec("jalr_e", 3'd0, 0, 1, 0, 0, 0, 0), 0, 1, 0);
        cyc(e_wb("jalr_wb", 3'd0, 2, 1), 0, 1, 0);

        instr = 32'h123450B7;
        cyc(e_fetch("lui_f", 1), 0, 1, 0);
        cyc(e_dec("lui_d", 3'd3, 0), 0, 1, 0);
        cyc(e_exec("lui_e", 3'd3, 2, 1, 0, 0, 0, 0), 0, 1, 0);
        cyc(e_wb("lui_wb", 3'd3, 0, 0), 0, 1, 0);

        instr = 32'h0000A083;
        cyc(e_fetch("ab_f", 1), 0, 1, 0);
        cyc(e_dec("ab_d", 3'd0, 0), 0, 1, 0);
        cyc(e_exec("ab_e", 3'd0, 0, 1, 0, 0, 0, 0), 0, 0, 0);
        cyc(e_mem("ab_mw", 3'd0, 0, 0), 0, 0, 0);
        cyc(base("ab_rst", 1, 1), 1, 0, 0);
        cyc(e_fetch("ab_f2w", 0), 0, 0, 0);
        cyc(e_fetch("ab_f2", 1), 0, 1, 0);
        cyc(e_dec("ab_d2", 3'd0, 0), 0, 1, 0);
        cyc(e_exec("ab_e2", 3'd0, 0, 1, 0, 0, 0, 0), 0, 1, 0);
        cyc(e_mem("ab_m2", 3'd0, 0, 0), 0, 1, 0);
        cyc(e_wb("ab_wb2", 3'd0, 1, 0), 0, 1, 0);

        instr = 32'h0000007F;
        cyc(e_fetch("ill_f", 1), 0, 1, 0);
        cyc(e_dec("ill_d", 3'd7, 1), 0, 1, 0);
        for (int i = 0; i < 21; i++) begin
            cyc(e_trap($sformatf("ill_trap%0d", i), 2'd1), 0, 1, 1);
        end
        cyc(base("ill_rst", 1, 1), 1, 1, 0);

        instr = 32'h00000073;
        cyc(e_fetch("ecall_f", 1), 0, 1, 0);
        cyc(e_dec("ecall_d", 3'd7, 1), 0, 1, 0);
        for (int i = 0; i < 21; i++) begin
            cyc(e_trap($sformatf("ecall_trap%0d", i), 2'd2), 0, 1, 0);
        end
        cyc(base("ecall_rst", 1, 0), 1, 0, 0);
        cyc(e_fetch("post_f", 0), 0, 0, 0);

        rst = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
